// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter in front of one shared BITS-wide adder.
// One operation is in flight at a time: IDLE (grant) -> ADD -> RESP.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   req_valid[i]     requester i presents operands
//   req_a, req_b     operands of requester i at [i*BITS +: BITS]
//   req_ready[i]     combinational one-hot grant, only ever high in IDLE
//   rsp_valid        result held (RESP state)
//   rsp_sum          BITS+1 wide unsigned sum, MSB is the carry-out
//   rsp_id           index of the requester that owns rsp_sum
//   rsp_ready        consumer accepts the result
//   busy             high whenever the FSM is not in IDLE
module adder_arbiter #(
  parameter int unsigned BITS = 4,
  parameter int unsigned NREQ = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NREQ-1:0]                       req_valid,
  input  logic [NREQ*BITS-1:0]                  req_a,
  input  logic [NREQ*BITS-1:0]                  req_b,
  output logic [NREQ-1:0]                       req_ready,
  output logic                                  rsp_valid,
  output logic [BITS:0]                         rsp_sum,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] rsp_id,
  input  logic                                  rsp_ready,
  output logic                                  busy
);

  localparam int unsigned ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned SUM_W = BITS + 1;

  typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [BITS-1:0]   a_q, a_d;
  logic [BITS-1:0]   b_q, b_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [NREQ-1:0]   grant_c;

  logic              found;
  logic [ID_W-1:0]   win;
  int unsigned       idx_u;

  // Round-robin search: first valid index starting at the pointer, wrapping mod NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx_u = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx_u = 32'(ptr_q) + k;
      if (idx_u >= NREQ) idx_u = idx_u - NREQ;
      if (!found && req_valid[ID_W'(idx_u)]) begin
        found = 1'b1;
        win   = ID_W'(idx_u);
      end
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    sum_d   = sum_q;
    grant_c = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_c[win] = 1'b1;
          a_d          = req_a[win*BITS +: BITS];
          b_d          = req_b[win*BITS +: BITS];
          id_d         = win;
          ptr_d        = (win == ID_W'(NREQ - 1)) ? '0 : win + ID_W'(1);
          state_d      = ADD;
        end
      end
      ADD: begin
        sum_d   = SUM_W'(a_q) + SUM_W'(b_q);
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
    end
  end

  // Grant is combinational; reset masks it so no strobe escapes while rst_n is low.
  assign req_ready = rst_n ? grant_c : '0;
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_sum   = sum_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter (BITS=4, NREQ=4).
// A negedge monitor predicts grants with a round-robin reference and keeps a
// scoreboard of expected {id, sum}; scenario tasks check timing-specific values.
module tb_adder_arbiter;

  localparam int BITS = 4;
  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [4:0]  rsp_sum;
  logic [1:0]  rsp_id;
  logic        rsp_ready;
  logic        busy;

  int checks = 0;
  int passed = 0;

  typedef struct {
    int id;
    int sum;
  } exp_t;

  exp_t sbq[$];
  int   m_state;  // 0 idle, 1 add, 2 resp
  int   m_ptr;

  adder_arbiter #(.BITS(BITS), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference monitor and scoreboard.
  always @(negedge clk) begin : monitor
    logic [3:0] exp_rdy;
    int         w;
    int         idx;
    exp_t       e;
    exp_t       got;
    if (!rst_n) begin
      m_state = 0;
      m_ptr   = 0;
      sbq.delete();
    end else begin
      exp_rdy = '0;
      w       = -1;
      if (m_state == 0) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (w < 0 && req_valid[idx]) w = idx;
        end
      end
      if (w >= 0) exp_rdy[w] = 1'b1;
      checks++;
      if (req_ready !== exp_rdy) $display("FAIL mon_req_ready t=%0t got=%b exp=%b", $time, req_ready, exp_rdy);
      else passed++;
      checks++;
      if (rsp_valid !== 1'(m_state == 2)) $display("FAIL mon_rsp_valid t=%0t got=%b exp=%0d", $time, rsp_valid, m_state == 2);
      else passed++;
      case (m_state)
        0: if (w >= 0) begin
          e.id  = w;
          e.sum = int'(req_a[w*BITS +: BITS]) + int'(req_b[w*BITS +: BITS]);
          sbq.push_back(e);
          m_ptr   = (w + 1) % NREQ;
          m_state = 1;
        end
        1: m_state = 2;
        default: if (rsp_ready) begin
          checks++;
          if (sbq.size() == 0) begin
            $display("FAIL mon_unexpected_rsp t=%0t sum=%0d id=%0d", $time, rsp_sum, rsp_id);
          end else begin
            got = sbq.pop_front();
            if (rsp_sum !== 5'(got.sum) || rsp_id !== 2'(got.id))
              $display("FAIL mon_rsp t=%0t got sum=%0d id=%0d exp sum=%0d id=%0d", $time, rsp_sum, rsp_id, got.sum, got.id);
            else passed++;
          end
          m_state = 0;
        end
      endcase
    end
  end

  // Wait (bounded) for the FSM to return to IDLE; callers check busy afterwards.
  task automatic drain();
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (!busy) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'b1111; req_a = 16'h1234; req_b = 16'h5678; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready got=%b exp=0000", req_ready); else passed++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); else passed++;
    checks++; if (rsp_sum !== 5'd0) $display("FAIL reset_rsp_sum got=%0d exp=0", rsp_sum); else passed++;
    checks++; if (rsp_id !== 2'd0) $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    rst_n = 1'b1; req_valid = 4'b0000;
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    req_valid = 4'b0001; req_a = 16'h0003; req_b = 16'h0004; rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) $display("FAIL single_grant got=%b exp=0001", req_ready); else passed++;
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) $display("FAIL single_add_ready got=%b exp=0000", req_ready); else passed++;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) $display("FAIL single_add_state rsp_valid=%b busy=%b exp 0/1", rsp_valid, busy); else passed++;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) $display("FAIL single_latency rsp_valid=%b exp=1", rsp_valid); else passed++;
    checks++; if (rsp_sum !== 5'd7 || rsp_id !== 2'd0) $display("FAIL single_result sum=%0d id=%0d exp 7/0", rsp_sum, rsp_id); else passed++;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL single_idle busy=%b rsp_valid=%b exp 0/0", busy, rsp_valid); else passed++;
  endtask

  task automatic test_overflow();
    @(posedge clk); #1;
    req_valid = 4'b0100; req_a = 16'h0F00; req_b = 16'h0F00; rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) $display("FAIL ovf_grant got=%b exp=0100", req_ready); else passed++;
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 5'b11110 || rsp_id !== 2'd2)
      $display("FAIL ovf_result valid=%b sum=%b id=%0d exp 1/11110/2", rsp_valid, rsp_sum, rsp_id);
    else passed++;
    drain();
    checks++; if (busy !== 1'b0) $display("FAIL ovf_drain busy=%b exp=0", busy); else passed++;
  endtask

  task automatic test_round_robin();
    int ids[5];
    int cyc[5];
    int ng;
    int exp_ids[5] = '{0, 1, 2, 3, 0};
    ng = 0;
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    req_valid = 4'b1111; req_a = 16'h4321; req_b = 16'hB9A8; rsp_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) begin
        checks++; if (!$onehot(req_ready)) $display("FAIL rr_onehot got=%b", req_ready); else passed++;
        ids[ng] = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) ids[ng] = i;
        cyc[ng] = t;
        ng++;
        if (ng == 5) break;
      end
    end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    checks++; if (ng != 5) $display("FAIL rr_timeout grants=%0d exp=5", ng); else passed++;
    for (int g = 0; g < ng; g++) begin
      checks++; if (ids[g] != exp_ids[g]) $display("FAIL rr_order grant%0d got=%0d exp=%0d", g, ids[g], exp_ids[g]); else passed++;
      if (g > 0) begin
        checks++; if (cyc[g] - cyc[g-1] != 3) $display("FAIL rr_interval grant%0d got=%0d exp=3", g, cyc[g] - cyc[g-1]); else passed++;
      end
    end
    drain();
    checks++; if (busy !== 1'b0) $display("FAIL rr_drain busy=%b exp=0", busy); else passed++;
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 4'b0100; req_a = 16'h0900; req_b = 16'h0500;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) $display("FAIL bp_grant got=%b exp=0100", req_ready); else passed++;
    @(posedge clk); #1;
    req_valid = 4'b1011;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || busy !== 1'b1) $display("FAIL bp_hold_valid cyc%0d valid=%b busy=%b exp 1/1", i, rsp_valid, busy); else passed++;
      checks++; if (rsp_sum !== 5'd14 || rsp_id !== 2'd2) $display("FAIL bp_hold_data cyc%0d sum=%0d id=%0d exp 14/2", i, rsp_sum, rsp_id); else passed++;
      checks++; if (req_ready !== 4'b0000) $display("FAIL bp_hold_ready cyc%0d got=%b exp=0000", i, req_ready); else passed++;
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1; req_valid = 4'b0000;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 5'd14) $display("FAIL bp_accept valid=%b sum=%0d exp 1/14", rsp_valid, rsp_sum); else passed++;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL bp_idle busy=%b valid=%b exp 0/0", busy, rsp_valid); else passed++;
  endtask

  task automatic test_pointer_skip();
    logic [3:0] exp_g[2];
    logic       got_grant;
    exp_g[0] = 4'b1000;
    exp_g[1] = 4'b0001;
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    req_valid = 4'b0010; req_a = 16'h4321; req_b = 16'h1111; rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) $display("FAIL skip_first got=%b exp=0010", req_ready); else passed++;
    @(posedge clk); #1;
    req_valid = 4'b1001;
    for (int g = 0; g < 2; g++) begin
      got_grant = 1'b0;
      for (int t = 0; t < 10; t++) begin
        @(negedge clk);
        if (req_ready != 4'b0000) begin
          got_grant = 1'b1;
          break;
        end
      end
      checks++; if (!got_grant || req_ready !== exp_g[g]) $display("FAIL skip_grant%0d got=%b exp=%b", g, req_ready, exp_g[g]); else passed++;
    end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    drain();
    checks++; if (busy !== 1'b0) $display("FAIL skip_drain busy=%b exp=0", busy); else passed++;
  endtask

  task automatic test_reset_in_add();
    @(posedge clk); #1;
    req_valid = 4'b0001; req_a = 16'h0001; req_b = 16'h0002; rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) $display("FAIL rst_add_grant got=%b exp=0001", req_ready); else passed++;
    @(posedge clk); #1;
    req_valid = 4'b0000; rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL rst_add_state busy=%b valid=%b exp 0/0", busy, rsp_valid); else passed++;
    checks++; if (rsp_sum !== 5'd0 || rsp_id !== 2'd0) $display("FAIL rst_add_data sum=%0d id=%0d exp 0/0", rsp_sum, rsp_id); else passed++;
    checks++; if (req_ready !== 4'b0000) $display("FAIL rst_add_ready got=%b exp=0000", req_ready); else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rst_add_ghost cyc%0d valid=%b busy=%b exp 0/0", i, rsp_valid, busy); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_round_robin();
    test_backpressure();
    test_pointer_skip();
    test_reset_in_add();
    checks++; if (sbq.size() != 0) $display("FAIL sb_leftover pending=%0d exp=0", sbq.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
